npc_ctrl: RTL and testbench

Multi-cycle sequencer for the NPC core. Owns the PC and instruction register, runs the fetch/decode/execute/memory/writeback loop, and does the valid/ack handshakes with instruction and data memory. Feeds the latched instruction to the decoder and consumes its control outputs (`stop_sim`, `memtoreg`, store flag). Gates register-file and PC writes so each instruction commits exactly once.

---
 rtl/npc_ctrl_pkg.sv | 17 +
 rtl/npc_timeout_cnt.sv | 31 +++
 rtl/npc_ctrl.sv | 95 +++++++++
 tb/tb_npc_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/npc_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer.
package npc_ctrl_pkg;

   typedef enum logic [2:0] {
      BOOT   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
   localparam int          TO_W             = 16;

endpackage

// File: rtl/npc_timeout_cnt.sv
// Wait-cycle counter for memory handshakes; expire fires on the TIMEOUT-th
// consecutive cycle counted without an ack.
import npc_ctrl_pkg::*;

module npc_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   // Combinational so the FSM leaves on the same edge the count would hit TIMEOUT.
   assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/npc_ctrl.sv
// NPC multi-cycle sequencer: owns PC/IR, runs fetch..writeback, and gates
// register-file and PC commits to once per retired instruction.
import npc_ctrl_pkg::*;

module npc_ctrl #(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   input  logic        stop_sim,
   input  logic        memtoreg,
   input  logic        is_store,
   input  logic [31:0] next_pc,
   output logic        dmem_req,
   input  logic        dmem_ack,
   output logic        rf_wen,
   output logic [31:0] pc,
   output logic [31:0] instret,
   output logic        halted,
   output logic        bus_err
);

   state_t state;
   logic   st_q;
   logic   busy, ack, expire;

   assign busy = (state == FETCH) || (state == MEM);
   assign ack  = ((state == FETCH) && imem_ack) || ((state == MEM) && dmem_ack);

   npc_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_to (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (!busy || ack),
      .en     (busy && !ack),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= BOOT;
         pc      <= RESET_PC;
         inst    <= '0;
         instret <= '0;
         bus_err <= 1'b0;
         st_q    <= 1'b0;
      end else begin
         case (state)
            BOOT:   state <= FETCH;
            FETCH:
               if (imem_ack) begin
                  inst  <= imem_rdata;
                  state <= DECODE;
               end else if (expire) begin
                  bus_err <= 1'b1;
                  state   <= HALT;
               end
            DECODE: state <= EXEC;
            EXEC: begin
               // Store flag is captured so rf_wen stays a pure state decode in WB.
               st_q <= is_store;
               if (stop_sim)                  state <= HALT;
               else if (memtoreg || is_store) state <= MEM;
               else                           state <= WB;
            end
            MEM:
               if (dmem_ack)
                  state <= WB;
               else if (expire) begin
                  bus_err <= 1'b1;
                  state   <= HALT;
               end
            WB: begin
               pc      <= next_pc;
               instret <= instret + 32'd1;
               state   <= FETCH;
            end
            HALT:   state <= HALT;
            default: state <= HALT;
         endcase
      end
   end

   assign imem_req  = (state == FETCH);
   assign dmem_req  = (state == MEM);
   assign rf_wen    = (state == WB) && !st_q;
   assign halted    = (state == HALT);
   assign imem_addr = pc;

endmodule

// File: tb/tb_npc_ctrl.sv
// Directed bench for npc_ctrl: per-instruction vector table plus hand-written
// halt, timeout and async-reset sequences. Decoder and memory are bench models.
module tb_npc_ctrl;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] ADDI   = 32'h0010_0093;
   localparam logic [31:0] LW     = 32'h0000_2103;
   localparam logic [31:0] SW     = 32'h0010_2023;
   localparam logic [31:0] EBRK   = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, dmem_req, rf_wen, halted, bus_err;
   logic        imem_ack = 1'b0, dmem_ack = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0, inst, pc, instret, next_pc;
   logic        stop_sim, memtoreg, is_store;

   int nvec  = 0;
   int nfail = 0;
   logic [31:0] exp_pc, exp_ir;

   always #5 clk = ~clk;

   // Minimal decoder / execute model
   assign stop_sim = (inst == EBRK);
   assign memtoreg = (inst[6:0] == 7'h03);
   assign is_store = (inst[6:0] == 7'h23);
   assign next_pc  = pc + 32'd4;

   npc_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .inst(inst),
      .stop_sim(stop_sim), .memtoreg(memtoreg), .is_store(is_store),
      .next_pc(next_pc), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .rf_wen(rf_wen), .pc(pc), .instret(instret),
      .halted(halted), .bus_err(bus_err)
   );

   typedef struct {
      logic [31:0] inst;
      int          iwait;   // imem ack on request cycle iwait (0-based)
      int          dwait;
      int          cyc;     // cycles from FETCH entry to next FETCH / HALT
      int          nrf;
      int          nd;
      logic        halt;
      logic        berr;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Enter with the DUT in reset; leaves it in FETCH at #1 after the edge.
   task automatic do_reset();
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      @(posedge clk); #1;
      check("rst_imem_req", {31'd0, imem_req}, 32'd0);
      check("rst_pc", pc, RST_PC);
      check("rst_inst", inst, 32'd0);
      check("rst_instret", instret, 32'd0);
      check("rst_halted_berr", {30'd0, halted, bus_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("boot_no_req", {31'd0, imem_req}, 32'd0);
      @(posedge clk); #1;
      check("cycle1_imem_req", {31'd0, imem_req}, 32'd1);
      exp_pc = RST_PC;
      exp_ir = 32'd0;
   endtask

   task automatic apply(input vec_t v, input string tag);
      int cyc = 0, nrf = 0, nd = 0, icnt = 0, dcnt = 0;
      bit left = 0;
      imem_rdata = v.inst;
      while (!(halted || (imem_req && left)) && cyc < 60) begin
         if (!imem_req) left = 1;
         imem_ack = imem_req && (icnt == v.iwait);
         if (imem_req) icnt++;
         dmem_ack = dmem_req && (dcnt == v.dwait);
         if (dmem_req) dcnt++;
         @(negedge clk);
         nrf += int'(rf_wen);
         nd  += int'(dmem_req);
         @(posedge clk); #1;
         cyc++;
      end
      imem_ack = 1'b0; dmem_ack = 1'b0;
      if (!v.halt) begin
         exp_pc = exp_pc + 32'd4;
         exp_ir = exp_ir + 32'd1;
      end
      check({tag, "_cycles"}, cyc, v.cyc);
      check({tag, "_rf_wen"}, nrf, v.nrf);
      check({tag, "_dmem_req"}, nd, v.nd);
      check({tag, "_pc"}, pc, exp_pc);
      check({tag, "_imem_addr"}, imem_addr, exp_pc);
      check({tag, "_instret"}, instret, exp_ir);
      check({tag, "_halted"}, {31'd0, halted}, {31'd0, v.halt});
      check({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, v.berr});
      if (!v.berr) check({tag, "_inst"}, inst, v.inst);
   endtask

   vec_t tbl[7];
   vec_t tv;

   initial begin
      tbl[0] = '{ADDI, 0, 0, 4, 1, 0, 1'b0, 1'b0};
      tbl[1] = '{ADDI, 2, 0, 6, 1, 0, 1'b0, 1'b0};
      tbl[2] = '{LW,   0, 0, 5, 1, 1, 1'b0, 1'b0};
      tbl[3] = '{LW,   0, 3, 8, 1, 4, 1'b0, 1'b0};
      tbl[4] = '{SW,   0, 1, 6, 0, 2, 1'b0, 1'b0};
      tbl[5] = '{ADDI, 3, 0, 7, 1, 0, 1'b0, 1'b0};
      tbl[6] = '{EBRK, 0, 0, 3, 0, 0, 1'b1, 1'b0};

      do_reset();
      for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("v%0d", i));

      // Halted core ignores acks and keeps pc/instret frozen.
      imem_ack = 1'b1; dmem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("halt_outputs", {28'd0, imem_req, dmem_req, rf_wen, halted}, 32'd1);
      end
      check("halt_pc", pc, 32'h8000_0018);
      check("halt_instret", instret, 32'd6);

      // Fetch never acked: bus error after 4 request cycles.
      do_reset();
      tv = '{ADDI, 99, 0, 4, 0, 0, 1'b1, 1'b1};
      apply(tv, "timeout");

      // Reset pulsed mid-MEM drops dmem_req without waiting for an edge.
      do_reset();
      apply(tbl[0], "pre_mem");
      imem_rdata = LW;
      imem_ack = 1'b1;
      for (int i = 0; i < 10 && !dmem_req; i++) begin
         @(posedge clk); #1;
      end
      imem_ack = 1'b0;
      check("mid_mem_dmem_req", {31'd0, dmem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_dmem_drop", {31'd0, dmem_req}, 32'd0);
      check("async_pc", pc, RST_PC);
      check("async_instret", instret, 32'd0);
      do_reset();
      apply(tbl[0], "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
